bcd_counter_n: RTL and testbench

- Parametrised N-digit BCD up/down counter.
- Adds enable, direction, synchronous clear, validated parallel load, terminal-count/carry output and optional saturation.
- Intended as a drop-in timebase/event counter for display and stopwatch paths. Cascadable via tc.

---
 rtl/bcd_counter_n_pkg.sv | 13 +
 rtl/bcd_counter_n_digit.sv | 26 ++
 rtl/bcd_counter_n.sv | 75 +++++++
 tb/tb_bcd_counter_n.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_n_pkg.sv
// Shared BCD digit type, digit limits and load-value validation helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// One BCD digit slice: next value and carry/borrow ripple to the next digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       up,
    input  logic       step_in,
    output bcd_digit_t d_next,
    output logic       step_out
);

    logic at_term;

    assign at_term  = up ? (d == BCD_MAX) : (d == BCD_MIN);
    // Higher digit moves only when this one steps across its limit.
    assign step_out = step_in & at_term;

    always_comb begin
        d_next = d;
        if (step_in) begin
            if (up) d_next = (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
            else    d_next = (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with clear, validated load, tc, wrap and saturation.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    logic [DIGITS-1:0][3:0] cnt_q;
    logic [DIGITS-1:0][3:0] cnt_nxt;
    logic [DIGITS:0]        step;
    logic                   load_ok;
    logic                   at_limit;

    assign step[0] = en;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .d        (cnt_q[k]),
            .up       (up),
            .step_in  (step[k]),
            .d_next   (cnt_nxt[k]),
            .step_out (step[k+1])
        );
    end

    // Ripple out of the top digit means every digit sits at the terminal value.
    assign at_limit = step[DIGITS];
    assign tc       = at_limit & ~clr & ~load;
    assign count    = cnt_q;

    always_comb begin
        load_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++)
            if (!bcd_valid(load_val[4*k +: 4])) load_ok = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                cnt_q <= '0;
            end else if (load) begin
                // All-or-nothing: a single bad digit rejects the whole word.
                if (load_ok) cnt_q    <= load_val;
                else         load_err <= 1'b1;
            end else if (en) begin
                if (!at_limit) begin
                    cnt_q <= cnt_nxt;
                end else if (SATURATE == 0) begin
                    cnt_q <= cnt_nxt;
                    wrap  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench: wrapping and saturating 3-digit counters driven in lockstep.
module tb_bcd_counter_n;

    logic        clk = 1'b0;
    logic        rst, clr, en, up, load;
    logic [11:0] load_val;
    logic [11:0] count0, count1;
    logic        tc0, tc1, wrap0, wrap1, lerr0, lerr1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(3), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count0), .tc(tc0), .wrap(wrap0), .load_err(lerr0)
    );

    bcd_counter_n #(.DIGITS(3), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count1), .tc(tc1), .wrap(wrap1), .load_err(lerr1)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; en = 0; up = 1; load = 0; load_val = 12'h000;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        step();
        checks++;
        if (count0 !== 12'h000 || wrap0 !== 1'b0 || lerr0 !== 1'b0) begin
            errors++; $display("FAIL reset0: count=%h wrap=%b err=%b, want 000 0 0", count0, wrap0, lerr0);
        end
        checks++;
        if (count1 !== 12'h000 || wrap1 !== 1'b0 || lerr1 !== 1'b0) begin
            errors++; $display("FAIL reset1: count=%h wrap=%b err=%b, want 000 0 0", count1, wrap1, lerr1);
        end
        rst = 0;
    endtask

    task automatic test_count_up();
        en = 1; up = 1;
        for (int i = 0; i < 1000; i++) begin
            #1;
            checks++;
            if (tc0 !== (i == 999)) begin
                errors++; $display("FAIL up_tc at %0d: tc=%b want %b", i, tc0, (i == 999));
            end
            step();
            checks++;
            if (count0 !== to_bcd((i + 1) % 1000) || wrap0 !== (i == 999)) begin
                errors++;
                $display("FAIL up_count after %0d: count=%h wrap=%b want %h %b",
                         i, count0, wrap0, to_bcd((i + 1) % 1000), (i == 999));
            end
        end
        step();
        checks++;
        if (count0 !== 12'h001 || wrap0 !== 1'b0) begin
            errors++; $display("FAIL up_after_wrap: count=%h wrap=%b want 001 0", count0, wrap0);
        end
        idle();
    endtask

    task automatic test_count_down();
        clr = 1;
        step();
        checks++;
        if (count0 !== 12'h000 || count1 !== 12'h000) begin
            errors++; $display("FAIL clr: count0=%h count1=%h want 000 000", count0, count1);
        end
        clr = 0; en = 1; up = 0;
        #1;
        checks++;
        if (tc0 !== 1'b1) begin
            errors++; $display("FAIL down_tc: tc=%b want 1", tc0);
        end
        step();
        checks++;
        if (count0 !== 12'h999 || wrap0 !== 1'b1) begin
            errors++; $display("FAIL down_wrap: count=%h wrap=%b want 999 1", count0, wrap0);
        end
        step();
        checks++;
        if (count0 !== 12'h998 || wrap0 !== 1'b0) begin
            errors++; $display("FAIL down_step: count=%h wrap=%b want 998 0", count0, wrap0);
        end
        idle();
    endtask

    task automatic test_load_carry();
        load = 1; load_val = 12'h499; en = 1; up = 1;
        #1;
        checks++;
        if (tc0 !== 1'b0) begin
            errors++; $display("FAIL load_tc: tc=%b want 0", tc0);
        end
        step();
        checks++;
        if (count0 !== 12'h499 || lerr0 !== 1'b0) begin
            errors++; $display("FAIL load_wins: count=%h err=%b want 499 0", count0, lerr0);
        end
        load = 0;
        step();
        checks++;
        if (count0 !== 12'h500) begin
            errors++; $display("FAIL carry: count=%h want 500", count0);
        end
        idle();
    endtask

    task automatic test_load_err();
        load = 1; load_val = 12'h123;
        step();
        load_val = 12'h4A2;
        step();
        checks++;
        if (count0 !== 12'h123 || lerr0 !== 1'b1 || wrap0 !== 1'b0) begin
            errors++; $display("FAIL bad_load: count=%h err=%b wrap=%b want 123 1 0", count0, lerr0, wrap0);
        end
        load = 0;
        step();
        checks++;
        if (count0 !== 12'h123 || lerr0 !== 1'b0) begin
            errors++; $display("FAIL bad_load_after: count=%h err=%b want 123 0", count0, lerr0);
        end
        idle();
    endtask

    task automatic test_saturate();
        load = 1; load_val = 12'h998;
        step();
        load = 0; en = 1; up = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (tc1 !== (i != 0)) begin
                errors++; $display("FAIL sat_tc step %0d: tc=%b want %b", i, tc1, (i != 0));
            end
            step();
            checks++;
            if (count1 !== 12'h999 || wrap1 !== 1'b0) begin
                errors++; $display("FAIL sat_hold step %0d: count=%h wrap=%b want 999 0", i, count1, wrap1);
            end
        end
        up = 0;
        step();
        checks++;
        if (count1 !== 12'h998) begin
            errors++; $display("FAIL sat_down: count=%h want 998", count1);
        end
        idle();
    endtask

    task automatic test_async_reset();
        load = 1; load_val = 12'h457;
        step();
        load = 0; en = 1; up = 1;
        #3 rst = 1;
        #1;
        checks++;
        if (count0 !== 12'h000 || count1 !== 12'h000) begin
            errors++; $display("FAIL async_rst: count0=%h count1=%h want 000 000", count0, count1);
        end
        step();
        rst = 0;
        step();
        checks++;
        if (count0 !== 12'h001) begin
            errors++; $display("FAIL resume1: count=%h want 001", count0);
        end
        step();
        checks++;
        if (count0 !== 12'h002) begin
            errors++; $display("FAIL resume2: count=%h want 002", count0);
        end
        clr = 1; load = 1; load_val = 12'h555;
        step();
        checks++;
        if (count0 !== 12'h000 || lerr0 !== 1'b0) begin
            errors++; $display("FAIL clr_over_load: count=%h err=%b want 000 0", count0, lerr0);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_carry();
        test_load_err();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
